// File: rtl/spi_input_frontend_if.sv
// Raw SPI pins into the front end and the conditioned levels and edge pulses it produces.
interface spi_input_frontend_if;
   logic sclk_in;
   logic cs_in;
   logic mosi_in;
   logic sclk;
   logic sclk_rise;
   logic sclk_fall;
   logic cs;
   logic cs_fall;
   logic cs_rise;
   logic mosi;

   modport master (
      output sclk_in, cs_in, mosi_in,
      input  sclk, sclk_rise, sclk_fall, cs, cs_fall, cs_rise, mosi
   );

   modport slave (
      input  sclk_in, cs_in, mosi_in,
      output sclk, sclk_rise, sclk_fall, cs, cs_fall, cs_rise, mosi
   );
endinterface

// File: rtl/spi_input_frontend.sv
// Synchronises and debounces the raw SPI pins; a level must hold WAIT cycles at the
// synchroniser output before the conditioned level moves, with a one-cycle edge pulse.
module spi_input_frontend_chan #(
   parameter int   WAIT    = 3,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);
   localparam int             CW      = $clog2(WAIT) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(WAIT - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic          sync0_q, sync0_d;
   logic          sync1_q, sync1_d;
   logic          cond_q, cond_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   always_comb begin
      sync0_d = pin;
      sync1_d = sync0_q;
      cond_d  = cond_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync1_q == cond_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         cond_d = sync1_q;
         cnt_d  = '0;
         rise_d = sync1_q;
         fall_d = ~sync1_q;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Synchroniser flops reset to the idle level so reset release never looks like an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync0_q <= RST_VAL;
         sync1_q <= RST_VAL;
         cond_q  <= RST_VAL;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync0_q <= sync0_d;
         sync1_q <= sync1_d;
         cond_q  <= cond_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level = cond_q;
   assign rise  = rise_q;
   assign fall  = fall_q;
endmodule

module spi_input_frontend #(
   parameter int SCLK_WAIT = 3,
   parameter int CS_WAIT   = 3,
   parameter int MOSI_WAIT = 3
) (
   input logic           clk,
   input logic           reset,
   spi_input_frontend_if.slave bus
);
   logic mosi_rise_unused;
   logic mosi_fall_unused;

   spi_input_frontend_chan #(.WAIT(SCLK_WAIT), .RST_VAL(1'b0)) u_sclk (
      .clk   (clk),
      .reset (reset),
      .pin   (bus.sclk_in),
      .level (bus.sclk),
      .rise  (bus.sclk_rise),
      .fall  (bus.sclk_fall)
   );

   // CS is active low, so its idle level is 1.
   spi_input_frontend_chan #(.WAIT(CS_WAIT), .RST_VAL(1'b1)) u_cs (
      .clk   (clk),
      .reset (reset),
      .pin   (bus.cs_in),
      .level (bus.cs),
      .rise  (bus.cs_rise),
      .fall  (bus.cs_fall)
   );

   spi_input_frontend_chan #(.WAIT(MOSI_WAIT), .RST_VAL(1'b0)) u_mosi (
      .clk   (clk),
      .reset (reset),
      .pin   (bus.mosi_in),
      .level (bus.mosi),
      .rise  (mosi_rise_unused),
      .fall  (mosi_fall_unused)
   );

   logic unused_ok;
   assign unused_ok = mosi_rise_unused ^ mosi_fall_unused;
endmodule

// File: tb/tb_spi_input_frontend.sv
// Directed bench for spi_input_frontend with WAIT=3 on every channel.
module tb_spi_input_frontend;
   logic clk;
   logic reset;
   int   n_pass;
   int   n_total;
   int   n_fail;

   spi_input_frontend_if ifc();

   spi_input_frontend #(.SCLK_WAIT(3), .CS_WAIT(3), .MOSI_WAIT(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitor samples 1 time unit after each rising edge.
   int   n_srise, n_sfall, n_cfall, n_crise;
   bit   ord_err, wid_err;
   logic p_sr, p_sf, p_cf, p_cr;

   task automatic clear_mon();
      n_srise = 0; n_sfall = 0; n_cfall = 0; n_crise = 0;
      ord_err = 1'b0; wid_err = 1'b0;
   endtask

   initial begin
      clear_mon();
      p_sr = 1'b0; p_sf = 1'b0; p_cf = 1'b0; p_cr = 1'b0;
   end

   always @(posedge clk) begin
      #1;
      if ((p_sr & ifc.sclk_rise) || (p_sf & ifc.sclk_fall) ||
          (p_cf & ifc.cs_fall) || (p_cr & ifc.cs_rise) ||
          (ifc.sclk_rise & ifc.sclk_fall) || (ifc.cs_rise & ifc.cs_fall))
         wid_err = 1'b1;
      if (ifc.cs_fall && (n_srise != 0 || n_sfall != 0 || n_crise != 0))
         ord_err = 1'b1;
      if (ifc.sclk_rise && (n_cfall != 1 || n_crise != 0 || n_srise != n_sfall))
         ord_err = 1'b1;
      if (ifc.sclk_fall && (n_cfall != 1 || n_crise != 0 || n_srise != n_sfall + 1))
         ord_err = 1'b1;
      if (ifc.cs_rise && (n_srise != n_sfall))
         ord_err = 1'b1;
      n_srise += int'(ifc.sclk_rise);
      n_sfall += int'(ifc.sclk_fall);
      n_cfall += int'(ifc.cs_fall);
      n_crise += int'(ifc.cs_rise);
      p_sr = ifc.sclk_rise; p_sf = ifc.sclk_fall;
      p_cf = ifc.cs_fall;   p_cr = ifc.cs_rise;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      assert (obs === exp_v) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [31:0] outs();
      return {25'd0, ifc.sclk, ifc.sclk_rise, ifc.sclk_fall, ifc.cs,
              ifc.cs_fall, ifc.cs_rise, ifc.mosi};
   endfunction

   localparam logic [31:0] IDLE = 32'b000_1000;

   logic [31:0] r;

   initial begin
      n_pass = 0; n_total = 0; n_fail = 0;

      // Reset with random pins, then release with pins at idle levels.
      reset = 1'b1;
      r = $urandom;
      ifc.sclk_in = r[0]; ifc.cs_in = r[1]; ifc.mosi_in = r[2];
      tick(1);
      chk("reset_cycle1", outs(), IDLE);
      tick(1);
      chk("reset_cycle2", outs(), IDLE);
      reset = 1'b0;
      ifc.sclk_in = 1'b0; ifc.cs_in = 1'b1; ifc.mosi_in = 1'b0;
      clear_mon();
      tick(20);
      chk("post_reset_no_pulse", 32'(n_srise + n_sfall + n_cfall + n_crise), 32'd0);
      chk("post_reset_levels", outs(), IDLE);

      // Clean SCLK rise: E0..E3 unchanged, E4 level and pulse, E5 pulse gone.
      ifc.sclk_in = 1'b1;
      tick(4);
      chk("rise_e3", outs(), IDLE);
      tick(1);
      chk("rise_e4", outs(), 32'b110_1000);
      tick(1);
      chk("rise_e5", outs(), 32'b100_1000);
      tick(9);
      ifc.sclk_in = 1'b0;
      tick(4);
      chk("fall_e3", outs(), 32'b100_1000);
      tick(1);
      chk("fall_e4", outs(), 32'b001_1000);
      tick(1);
      chk("fall_e5", outs(), IDLE);

      // Two-cycle glitch is filtered; a four-cycle pulse passes through.
      clear_mon();
      ifc.sclk_in = 1'b1;
      tick(2);
      ifc.sclk_in = 1'b0;
      tick(20);
      chk("glitch2_pulses", 32'(n_srise + n_sfall), 32'd0);
      chk("glitch2_level", 32'(ifc.sclk), 32'd0);
      ifc.sclk_in = 1'b1;
      tick(4);
      ifc.sclk_in = 1'b0;
      tick(20);
      chk("pulse4_rises", 32'(n_srise), 32'd1);
      chk("pulse4_falls", 32'(n_sfall), 32'd1);
      chk("pulse4_level", 32'(ifc.sclk), 32'd0);

      // Frame: CS low, 8 SCLK periods of 16 cycles, CS high.
      clear_mon();
      ifc.cs_in = 1'b0;
      tick(10);
      for (int p = 0; p < 8; p++) begin
         ifc.sclk_in = 1'b1;
         tick(8);
         ifc.sclk_in = 1'b0;
         tick(8);
      end
      tick(10);
      ifc.cs_in = 1'b1;
      tick(10);
      chk("frame_cs_fall", 32'(n_cfall), 32'd1);
      chk("frame_sclk_rise", 32'(n_srise), 32'd8);
      chk("frame_sclk_fall", 32'(n_sfall), 32'd8);
      chk("frame_cs_rise", 32'(n_crise), 32'd1);
      chk("frame_order", 32'(ord_err), 32'd0);
      chk("frame_width", 32'(wid_err), 32'd0);
      chk("frame_end_levels", outs(), IDLE);

      // All three pins change together: all outputs move on E4.
      ifc.cs_in = 1'b0; ifc.mosi_in = 1'b1; ifc.sclk_in = 1'b1;
      tick(4);
      chk("simul_e3", outs(), IDLE);
      tick(1);
      chk("simul_e4", outs(), 32'b110_0101);
      tick(1);
      chk("simul_e5", outs(), 32'b100_0001);
      ifc.cs_in = 1'b1; ifc.mosi_in = 1'b0; ifc.sclk_in = 1'b0;
      tick(10);
      chk("simul_restore", outs(), IDLE);

      // Reset on E2 of an SCLK rise: aborted count, then full latency from E3.
      clear_mon();
      ifc.sclk_in = 1'b1;
      tick(2);
      reset = 1'b1;
      tick(1);
      chk("midreset_e2", outs(), IDLE);
      reset = 1'b0;
      tick(4);
      chk("midreset_e6_level", outs(), IDLE);
      chk("midreset_no_pulse", 32'(n_srise + n_sfall), 32'd0);
      tick(1);
      chk("midreset_e7", outs(), 32'b110_1000);
      chk("midreset_one_rise", 32'(n_srise), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
